// File: rtl/spi_flash_rd_seq.sv
// spi_flash_rd_seq
//   Boot-time sequencer that copies a block of 32-bit words from a SPI NOR
//   flash (READ 0x03, 24-bit address) into instruction RAM over spi0.
//
//   Parameters
//     CLK_DIV  clk cycles per SCK half-period (>= 1)
//     LEN_W    width of the word count and RAM word address
//
//   Ports
//     clk, rst       system clock, asynchronous active-high reset
//     start_i        start request, sampled only while idle
//     flash_addr_i   flash byte address, captured on accepted start
//     word_cnt_i     number of words to copy, captured on accepted start
//     abort_i        early termination request (ignored while idle)
//     busy_o         transfer in progress
//     done_o         one-cycle completion pulse (normal, empty or aborted)
//     spi_ss_o       flash chip select, active-low
//     spi_clk_o      SCK, mode 0
//     spi_mosi_o     serial data to flash, MSB first
//     spi_miso_i     serial data from flash
//     wr_en_o        RAM write strobe, one cycle per word
//     wr_addr_o      RAM word index
//     wr_data_o      assembled word, little-endian byte packing
module spi_flash_rd_seq #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [23:0]      flash_addr_i,
  input  logic [LEN_W-1:0] word_cnt_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             spi_ss_o,
  output logic             spi_clk_o,
  output logic             spi_mosi_o,
  input  logic             spi_miso_i,
  output logic             wr_en_o,
  output logic [LEN_W-1:0] wr_addr_o,
  output logic [31:0]      wr_data_o
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [7:0]       CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, CMD, ADDR, DATA, CS_HOLD, DONE
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  // Bits still to be sent after the one currently on MOSI.
  logic [30:0]      tx_sr;
  logic [30:0]      rx_sr;
  logic [LEN_W-1:0] word_cnt_q;
  logic [LEN_W-1:0] word_idx;

  logic [31:0]      rx_next;
  logic             half_end;
  logic             bit_last;
  logic             abortable;

  always_comb begin
    rx_next   = {rx_sr, spi_miso_i};
    half_end  = (div_cnt == DIV_LAST);
    abortable = (state == CS_SETUP) || (state == CMD) ||
                (state == ADDR) || (state == DATA);
    case (state)
      CMD:     bit_last = (bit_cnt == 5'd7);
      ADDR:    bit_last = (bit_cnt == 5'd23);
      default: bit_last = (bit_cnt == 5'd31);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      word_cnt_q <= '0;
      word_idx   <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      spi_ss_o   <= 1'b1;
      spi_clk_o  <= 1'b0;
      spi_mosi_o <= 1'b0;
      wr_en_o    <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
    end else begin
      wr_en_o <= 1'b0;
      done_o  <= 1'b0;
      if (abort_i && abortable) begin
        // Partial word is dropped; the chip-select hold still runs.
        state      <= CS_HOLD;
        spi_clk_o  <= 1'b0;
        spi_mosi_o <= 1'b0;
        div_cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              word_cnt_q <= word_cnt_i;
              tx_sr      <= {CMD_READ[6:0], flash_addr_i};
              div_cnt    <= '0;
              bit_cnt    <= '0;
              word_idx   <= '0;
              if (word_cnt_i == '0) begin
                state <= DONE;
              end else begin
                state      <= CS_SETUP;
                busy_o     <= 1'b1;
                spi_ss_o   <= 1'b0;
                spi_mosi_o <= CMD_READ[7];
              end
            end
          end
          CS_SETUP: begin
            if (half_end) begin
              div_cnt <= '0;
              state   <= CMD;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          CMD, ADDR, DATA: begin
            if (!half_end) begin
              div_cnt <= div_cnt + 1'b1;
            end else begin
              div_cnt <= '0;
              if (!spi_clk_o) begin
                // Rising SCK: sample MISO; the 32nd data bit completes a word.
                spi_clk_o <= 1'b1;
                rx_sr     <= rx_next[30:0];
                if (state == DATA && bit_last) begin
                  wr_en_o   <= 1'b1;
                  wr_addr_o <= word_idx;
                  wr_data_o <= {rx_next[7:0], rx_next[15:8],
                                rx_next[23:16], rx_next[31:24]};
                end
              end else begin
                // Falling SCK: end of bit, shift out the next MOSI bit.
                spi_clk_o  <= 1'b0;
                spi_mosi_o <= tx_sr[30];
                tx_sr      <= {tx_sr[29:0], 1'b0};
                if (bit_last) begin
                  bit_cnt <= '0;
                  case (state)
                    CMD:  state <= ADDR;
                    ADDR: state <= DATA;
                    default: begin
                      word_idx <= word_idx + 1'b1;
                      if (word_idx == word_cnt_q - 1'b1) state <= CS_HOLD;
                    end
                  endcase
                end else begin
                  bit_cnt <= bit_cnt + 5'd1;
                end
              end
            end
          end
          CS_HOLD: begin
            if (half_end) begin
              div_cnt  <= '0;
              spi_ss_o <= 1'b1;
              state    <= DONE;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          DONE: begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// Bench for spi_flash_rd_seq: two instances (CLK_DIV=2 and CLK_DIV=1) share
// one behavioural flash model through a selector; RAM writes are checked
// against a scoreboard filled from the model memory when a start is issued.
module tb_spi_flash_rd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        sel;
  logic [23:0] faddr;
  logic [15:0] fcnt;
  logic        miso;

  logic        start2, start1;
  logic        b2_busy, b2_done, b2_ss, b2_sck, b2_mosi, b2_wr_en;
  logic [15:0] b2_wr_addr;
  logic [31:0] b2_wr_data;
  logic        b1_busy, b1_done, b1_ss, b1_sck, b1_mosi, b1_wr_en;
  logic [15:0] b1_wr_addr;
  logic [31:0] b1_wr_data;

  logic        f_busy, f_done, f_ss, f_sck, f_mosi, f_wr_en;
  logic [15:0] f_wr_addr;
  logic [31:0] f_wr_data;

  always #5 clk = ~clk;

  assign start2    = start & ~sel;
  assign start1    = start & sel;
  assign f_busy    = sel ? b1_busy    : b2_busy;
  assign f_done    = sel ? b1_done    : b2_done;
  assign f_ss      = sel ? b1_ss      : b2_ss;
  assign f_sck     = sel ? b1_sck     : b2_sck;
  assign f_mosi    = sel ? b1_mosi    : b2_mosi;
  assign f_wr_en   = sel ? b1_wr_en   : b2_wr_en;
  assign f_wr_addr = sel ? b1_wr_addr : b2_wr_addr;
  assign f_wr_data = sel ? b1_wr_data : b2_wr_data;

  spi_flash_rd_seq #(.CLK_DIV(2), .LEN_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .flash_addr_i(faddr),
    .word_cnt_i(fcnt), .abort_i(abort), .busy_o(b2_busy), .done_o(b2_done),
    .spi_ss_o(b2_ss), .spi_clk_o(b2_sck), .spi_mosi_o(b2_mosi),
    .spi_miso_i(miso), .wr_en_o(b2_wr_en), .wr_addr_o(b2_wr_addr),
    .wr_data_o(b2_wr_data)
  );

  spi_flash_rd_seq #(.CLK_DIV(1), .LEN_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .flash_addr_i(faddr),
    .word_cnt_i(fcnt), .abort_i(abort), .busy_o(b1_busy), .done_o(b1_done),
    .spi_ss_o(b1_ss), .spi_clk_o(b1_sck), .spi_mosi_o(b1_mosi),
    .spi_miso_i(miso), .wr_en_o(b1_wr_en), .wr_addr_o(b1_wr_addr),
    .wr_data_o(b1_wr_data)
  );

  // Flash model: 1 KiB image, READ command, mode 0.
  logic [7:0]  mem [1024];
  int          fbits;
  logic [31:0] hdr;

  always @(negedge f_ss) begin
    fbits = 0;
    hdr   = '0;
  end
  always @(posedge f_sck) if (!f_ss) begin
    if (fbits < 32) hdr = {hdr[30:0], f_mosi};
    fbits++;
  end
  always @(negedge f_sck) if (!f_ss && fbits >= 32) begin
    int idx;
    logic [7:0] b;
    idx  = fbits - 32;
    b    = mem[(int'(hdr[9:0]) + idx / 8) % 1024];
    miso <= b[7 - (idx % 8)];
  end

  // Scoreboard and monitors.
  typedef struct { logic [15:0] a; logic [31:0] d; } wr_t;
  wr_t sb[$];
  int  checks = 0, failures = 0;
  int  wr_cnt = 0, done_cnt = 0, ss_falls = 0;
  bit  busy_seen = 1'b0;

  always @(negedge f_ss) ss_falls++;

  always @(negedge clk) begin
    if (f_busy) busy_seen = 1'b1;
    if (f_done) done_cnt++;
    if (f_wr_en) begin
      wr_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", f_wr_addr, f_wr_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if ({f_wr_addr, f_wr_data} !== {e.a, e.d}) begin
          failures++;
          $display("FAIL wr_word: got addr=%0d data=%h, required addr=%0d data=%h",
                   f_wr_addr, f_wr_data, e.a, e.d);
        end
      end
    end
  end

  function automatic int ix(input logic [23:0] a, input int off);
    return (int'(a[9:0]) + off) % 1024;
  endfunction

  // Drives a one-cycle start and queues the words expected to be written.
  task automatic do_start(input logic [23:0] a, input logic [15:0] n, input int nexp);
    @(negedge clk);
    faddr = a;
    fcnt  = n;
    start = 1'b1;
    for (int w = 0; w < nexp; w++) begin
      wr_t e;
      e.a = 16'(w);
      e.d = {mem[ix(a, 4*w+3)], mem[ix(a, 4*w+2)], mem[ix(a, 4*w+1)], mem[ix(a, 4*w)]};
      sb.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycles until done_o is seen, -1 if it never arrives.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 5000; k++) begin
      @(posedge clk);
      #1;
      if (f_done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; sel = 1'b0;
    faddr = '0; fcnt = '0; miso = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({f_busy, f_done, f_ss, f_sck, f_mosi, f_wr_en, f_wr_addr, f_wr_data} !==
        {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_values: got busy=%b done=%b ss=%b sck=%b mosi=%b wr_en=%b addr=%h data=%h",
               f_busy, f_done, f_ss, f_sck, f_mosi, f_wr_en, f_wr_addr, f_wr_data);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_single_word();
    int cyc, w0, s0;
    w0 = wr_cnt; s0 = ss_falls;
    do_start(24'h000100, 16'd1, 1);
    wait_done(cyc);
    checks++;
    if (cyc != 261) begin failures++; $display("FAIL single_latency: got %0d required 261", cyc); end
    checks++;
    if ({f_busy, f_ss} !== 2'b01) begin
      failures++; $display("FAIL single_done_state: got busy=%b ss=%b required busy=0 ss=1", f_busy, f_ss);
    end
    checks++;
    if (hdr !== 32'h03000100) begin failures++; $display("FAIL single_mosi: got %h required 03000100", hdr); end
    checks++;
    if (wr_cnt - w0 != 1 || ss_falls - s0 != 1) begin
      failures++; $display("FAIL single_counts: got writes=%0d ss_falls=%0d required 1 1", wr_cnt - w0, ss_falls - s0);
    end
  endtask

  task automatic test_multi_word();
    int cyc, w0, s0;
    w0 = wr_cnt; s0 = ss_falls;
    do_start(24'h000000, 16'd3, 3);
    wait_done(cyc);
    checks++;
    if (cyc != 2*(66+64*3)+1) begin failures++; $display("FAIL multi_latency: got %0d required %0d", cyc, 2*(66+64*3)+1); end
    checks++;
    if (wr_cnt - w0 != 3) begin failures++; $display("FAIL multi_writes: got %0d required 3", wr_cnt - w0); end
    checks++;
    if (ss_falls - s0 != 1) begin failures++; $display("FAIL multi_ss_low: got %0d required 1", ss_falls - s0); end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL multi_sb_empty: got %0d pending required 0", sb.size()); end
  endtask

  task automatic test_zero_len();
    int cyc, w0, s0;
    w0 = wr_cnt; s0 = ss_falls; busy_seen = 1'b0;
    do_start(24'h000040, 16'd0, 0);
    wait_done(cyc);
    checks++;
    if (cyc != 1) begin failures++; $display("FAIL zero_latency: got %0d required 1", cyc); end
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_seen, 8'(ss_falls - s0), 8'(wr_cnt - w0)} !== 17'h0) begin
      failures++; $display("FAIL zero_quiet: got busy_seen=%b ss_falls=%0d writes=%0d required 0 0 0",
                           busy_seen, ss_falls - s0, wr_cnt - w0);
    end
  endtask

  task automatic test_abort();
    int cyc, w0, d0;
    w0 = wr_cnt; d0 = done_cnt;
    do_start(24'h000020, 16'd4, 2);
    repeat (427) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checks++;
    if ({f_sck, f_ss} !== 2'b00) begin failures++; $display("FAIL abort_sck_low: got sck=%b ss=%b required 0 0", f_sck, f_ss); end
    @(posedge clk); #1;
    checks++;
    if (f_ss !== 1'b0) begin failures++; $display("FAIL abort_ss_hold: got %b required 0", f_ss); end
    @(posedge clk); #1;
    checks++;
    if (f_ss !== 1'b1) begin failures++; $display("FAIL abort_ss_rise: got %b required 1", f_ss); end
    wait_done(cyc);
    checks++;
    if (cyc != 1) begin failures++; $display("FAIL abort_done: got %0d required 1", cyc); end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_cnt - w0 != 2 || done_cnt - d0 != 1) begin
      failures++; $display("FAIL abort_counts: got writes=%0d dones=%0d required 2 1", wr_cnt - w0, done_cnt - d0);
    end
    do_start(24'h000100, 16'd1, 1);
    wait_done(cyc);
    checks++;
    if (cyc != 261) begin failures++; $display("FAIL abort_restart: got %0d required 261", cyc); end
  endtask

  task automatic test_restart_and_reset();
    int cyc, w0;
    w0 = wr_cnt;
    do_start(24'h000040, 16'd2, 2);
    repeat (50) @(posedge clk);
    @(negedge clk);
    faddr = 24'h000200; fcnt = 16'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc != 2*(66+128)+1-51) begin failures++; $display("FAIL busy_start_latency: got %0d required %0d", cyc, 2*(66+128)+1-51); end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_cnt - w0 != 2) begin failures++; $display("FAIL busy_start_writes: got %0d required 2", wr_cnt - w0); end
    do_start(24'h000010, 16'd1, 1);
    repeat (60) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({f_busy, f_ss} !== 2'b10) begin failures++; $display("FAIL pre_rst_active: got busy=%b ss=%b required 1 0", f_busy, f_ss); end
    rst = 1'b1;
    #1;
    checks++;
    if ({f_busy, f_done, f_ss, f_sck, f_mosi, f_wr_en, f_wr_addr, f_wr_data} !==
        {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0}) begin
      failures++;
      $display("FAIL mid_reset: got busy=%b done=%b ss=%b sck=%b mosi=%b wr_en=%b addr=%h data=%h",
               f_busy, f_done, f_ss, f_sck, f_mosi, f_wr_en, f_wr_addr, f_wr_data);
    end
    sb.delete();
    @(negedge clk) rst = 1'b0;
    w0 = wr_cnt;
    repeat (300) @(negedge clk);
    checks++;
    if (wr_cnt != w0 || f_ss !== 1'b1) begin failures++; $display("FAIL post_reset_idle: got writes=%0d ss=%b required 0 1", wr_cnt - w0, f_ss); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk) sel = 1'b1;
    do_start(24'h000080, 16'd2, 2);
    wait_done(cyc);
    checks++;
    if (cyc != 66+128+1) begin failures++; $display("FAIL b2b_first_latency: got %0d required %0d", cyc, 66+128+1); end
    do_start(24'h0003F0, 16'd3, 3);
    wait_done(cyc);
    checks++;
    if (cyc != 66+192+1) begin failures++; $display("FAIL b2b_second_latency: got %0d required %0d", cyc, 66+192+1); end
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL b2b_sb_empty: got %0d pending required 0", sb.size()); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    mem[256] = 8'h11; mem[257] = 8'h22; mem[258] = 8'h33; mem[259] = 8'h44;
    test_reset();
    test_single_word();
    test_multi_word();
    test_zero_len();
    test_abort();
    test_restart_and_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
